// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encoding, requester ids and arbitration helper.
// Rev 1.0
`default_nettype none

package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_GRANT_I = 2'b01,
      ST_GRANT_D = 2'b10,
      ST_RELEASE = 2'b11
   } state_e;

   localparam logic REQ_I = 1'b0;
   localparam logic REQ_D = 1'b1;

   // Data normally wins; fetch wins only once it has been passed over STARVE_LIMIT times.
   function automatic logic pick_winner(input logic i_req, input logic d_req, input logic at_limit);
      return (d_req && !(i_req && at_limit)) ? REQ_D : REQ_I;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and controller buses of the arbiter.
// Rev 1.0
`default_nettype none

interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              i_read;
   logic [ADDR_W-1:0] i_addr;
   logic [DATA_W-1:0] i_rdata;
   logic              i_ready;

   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ready;

   logic              m_read;
   logic              m_write;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic [DATA_W-1:0] m_rdata;
   logic              m_ready;

   logic              busy;

   // slave is the arbiter's view; master is the surrounding pipeline plus controller.
   modport slave (
      input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, m_rdata, m_ready,
      output i_rdata, i_ready, d_rdata, d_ready, m_read, m_write, m_addr, m_wdata, busy
   );

   modport master (
      output i_read, i_addr, d_read, d_write, d_addr, d_wdata, m_rdata, m_ready,
      input  i_rdata, i_ready, d_rdata, d_ready, m_read, m_write, m_addr, m_wdata, busy
   );

endinterface

`default_nettype wire

// File: rtl/mem_arbiter_starve.sv
// mem_arbiter_starve: saturating count of data grants taken while fetch waited.
// Rev 1.0
`default_nettype none

module mem_arbiter_starve #(
   parameter int LIMIT = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic inc_i,
   input  logic clr_i,
   output logic at_limit_o
);

   localparam int CNT_W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != LIMIT_C)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_limit_o = (cnt_q == LIMIT_C);

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises fetch and data accesses onto one memory controller port.
// Rev 1.0
`default_nettype none

module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clock,
   input  logic          reset,
   mem_arbiter_if.slave  bus
);

   state_e            state_q, state_d;
   logic              m_read_q, m_read_d;
   logic              m_write_q, m_write_d;
   logic [ADDR_W-1:0] m_addr_q, m_addr_d;
   logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              i_ready_q, i_ready_d;
   logic              d_ready_q, d_ready_d;

   logic              d_req;
   logic              at_limit;
   logic              starve_inc;
   logic              starve_clr;

   assign d_req = bus.d_read | bus.d_write;

   mem_arbiter_starve #(
      .LIMIT      (STARVE_LIMIT)
   ) u_starve (
      .clock      (clock),
      .reset      (reset),
      .inc_i      (starve_inc),
      .clr_i      (starve_clr),
      .at_limit_o (at_limit)
   );

   always_comb begin
      state_d    = state_q;
      m_read_d   = m_read_q;
      m_write_d  = m_write_q;
      m_addr_d   = m_addr_q;
      m_wdata_d  = m_wdata_q;
      i_rdata_d  = i_rdata_q;
      d_rdata_d  = d_rdata_q;
      i_ready_d  = 1'b0;
      d_ready_d  = 1'b0;
      starve_inc = 1'b0;
      starve_clr = 1'b0;

      case (state_q)
         ST_IDLE: begin
            starve_clr = ~bus.i_read;
            if (d_req || bus.i_read) begin
               if (pick_winner(bus.i_read, d_req, at_limit) == REQ_D) begin
                  state_d    = ST_GRANT_D;
                  m_addr_d   = bus.d_addr;
                  m_wdata_d  = bus.d_wdata;
                  m_write_d  = bus.d_write;
                  m_read_d   = bus.d_read & ~bus.d_write;
                  starve_inc = bus.i_read;
               end else begin
                  state_d    = ST_GRANT_I;
                  m_addr_d   = bus.i_addr;
                  m_wdata_d  = '0;
                  m_write_d  = 1'b0;
                  m_read_d   = 1'b1;
                  starve_clr = 1'b1;
               end
            end
         end

         ST_GRANT_I: begin
            if (bus.m_ready || !bus.i_read) begin
               state_d   = ST_RELEASE;
               m_read_d  = 1'b0;
               m_write_d = 1'b0;
               if (bus.m_ready) begin
                  i_rdata_d = bus.m_rdata;
                  i_ready_d = 1'b1;
               end
            end
         end

         ST_GRANT_D: begin
            // Completion takes precedence over a request dropped in the same cycle.
            if (bus.m_ready || !d_req) begin
               state_d   = ST_RELEASE;
               m_read_d  = 1'b0;
               m_write_d = 1'b0;
               if (bus.m_ready) begin
                  d_ready_d = 1'b1;
                  if (!m_write_q) begin
                     d_rdata_d = bus.m_rdata;
                  end
               end
            end
         end

         ST_RELEASE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         m_read_q  <= 1'b0;
         m_write_q <= 1'b0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
         i_ready_q <= 1'b0;
         d_ready_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         m_read_q  <= m_read_d;
         m_write_q <= m_write_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
         i_ready_q <= i_ready_d;
         d_ready_q <= d_ready_d;
      end
   end

   assign bus.m_read  = m_read_q;
   assign bus.m_write = m_write_q;
   assign bus.m_addr  = m_addr_q;
   assign bus.m_wdata = m_wdata_q;
   assign bus.i_rdata = i_rdata_q;
   assign bus.i_ready = i_ready_q;
   assign bus.d_rdata = d_rdata_q;
   assign bus.d_ready = d_ready_q;
   assign bus.busy    = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, corner sequences and randomized traffic against a transaction model.
// Rev 1.0
`default_nettype none

module tb_mem_arbiter;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int LIM = 4;

   logic clock = 1'b0;
   logic reset = 1'b0;

   mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_arbiter #(
      .ADDR_W       (AW),
      .DATA_W       (DW),
      .STARVE_LIMIT (LIM)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int            checks   = 0;
   int            failures = 0;
   int            starve_m = 0;
   logic [DW-1:0] exp_i_rdata = '0;
   logic [DW-1:0] exp_d_rdata = '0;

   typedef struct {
      logic          ir;
      logic          dr;
      logic          dw;
      logic [AW-1:0] ia;
      logic [AW-1:0] da;
      logic [DW-1:0] dwd;
      int            lat;
      logic [DW-1:0] rd;
      logic          exp_d;
      logic          exp_mr;
      logic          exp_mw;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string tag, input string what, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s %s: got %0h expected %0h", tag, what, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   // Runs one access from an IDLE cycle whose requests are already on the bus.
   task automatic run_txn(input string tag, input logic exp_d, input logic exp_mr, input logic exp_mw,
                          input int lat, input logic [DW-1:0] rdata);
      logic          ip;
      logic [AW-1:0] ea;
      logic [DW-1:0] ew;
      ip = bus.i_read;
      ea = exp_d ? bus.d_addr : bus.i_addr;
      ew = exp_d ? bus.d_wdata : '0;
      if (exp_d) starve_m = ip ? ((starve_m < LIM) ? starve_m + 1 : LIM) : 0;
      else       starve_m = 0;

      tick();
      chk(tag, "m_read",  bus.m_read,  exp_mr);
      chk(tag, "m_write", bus.m_write, exp_mw);
      chk(tag, "m_addr",  bus.m_addr,  ea);
      chk(tag, "m_wdata", bus.m_wdata, ew);
      chk(tag, "busy",    bus.busy,    1'b1);

      for (int k = 0; k < lat; k++) begin
         if (exp_d) bus.d_addr = $urandom;
         else       bus.i_addr = $urandom;
         bus.m_rdata = $urandom;
         tick();
         chk(tag, "hold m_addr", bus.m_addr, ea);
         chk(tag, "hold strobe", {bus.m_read, bus.m_write}, {exp_mr, exp_mw});
         chk(tag, "early ready", {bus.i_ready, bus.d_ready}, 2'b00);
      end

      bus.m_ready = 1'b1;
      bus.m_rdata = rdata;
      tick();
      bus.m_ready = 1'b0;
      bus.m_rdata = $urandom;
      if (!exp_d)      exp_i_rdata = rdata;
      else if (exp_mr) exp_d_rdata = rdata;
      chk(tag, "i_ready pulse", bus.i_ready, !exp_d);
      chk(tag, "d_ready pulse", bus.d_ready, exp_d);
      chk(tag, "release strobe", {bus.m_read, bus.m_write}, 2'b00);
      chk(tag, "release busy", bus.busy, 1'b1);
      chk(tag, "i_rdata", bus.i_rdata, exp_i_rdata);
      chk(tag, "d_rdata", bus.d_rdata, exp_d_rdata);
      if (exp_d) begin
         bus.d_read  = 1'b0;
         bus.d_write = 1'b0;
      end else begin
         bus.i_read = 1'b0;
      end

      tick();
      chk(tag, "idle ready", {bus.i_ready, bus.d_ready}, 2'b00);
      chk(tag, "idle busy", bus.busy, 1'b0);
      chk(tag, "idle strobe", {bus.m_read, bus.m_write}, 2'b00);
   endtask

   initial begin
      logic ip, dp, ed;
      int   op;

      vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h0,   32'h0,  3, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0,   32'h200, 32'h55, 0, 32'h11111111, 1'b1, 1'b0, 1'b1};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h300, 32'h0,  1, 32'h12345678, 1'b1, 1'b1, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0,   32'h400, 32'hAA, 2, 32'hCAFEF00D, 1'b1, 1'b0, 1'b1};
      vecs[4] = '{1'b1, 1'b0, 1'b1, 32'h500, 32'h200, 32'h55, 1, 32'h22222222, 1'b1, 1'b0, 1'b1};
      vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h500, 32'h0,   32'h0,  0, 32'h0BADCAFE, 1'b0, 1'b1, 1'b0};

      bus.i_read  = 1'b0;
      bus.i_addr  = '0;
      bus.d_read  = 1'b0;
      bus.d_write = 1'b0;
      bus.d_addr  = '0;
      bus.d_wdata = '0;
      bus.m_rdata = '0;
      bus.m_ready = 1'b0;

      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("reset", "strobes", {bus.m_read, bus.m_write}, 2'b00);
      chk("reset", "readies", {bus.i_ready, bus.d_ready}, 2'b00);
      chk("reset", "busy", bus.busy, 1'b0);
      chk("reset", "m_addr", bus.m_addr, '0);
      chk("reset", "rdata", {bus.i_rdata, bus.d_rdata}, '0);

      for (int v = 0; v < 6; v++) begin
         bus.i_read  = vecs[v].ir;
         bus.i_addr  = vecs[v].ia;
         bus.d_read  = vecs[v].dr;
         bus.d_write = vecs[v].dw;
         bus.d_addr  = vecs[v].da;
         bus.d_wdata = vecs[v].dwd;
         run_txn($sformatf("vec%0d", v), vecs[v].exp_d, vecs[v].exp_mr, vecs[v].exp_mw,
                 vecs[v].lat, vecs[v].rd);
      end

      // Starvation: fetch held while data keeps re-requesting.
      bus.i_read = 1'b1;
      bus.i_addr = 32'h600;
      for (int k = 0; k < LIM; k++) begin
         bus.d_read = 1'b1;
         bus.d_addr = 32'h700 + k;
         run_txn($sformatf("starve_d%0d", k), 1'b1, 1'b1, 1'b0, k % 2, 32'h7000 + k);
      end
      bus.d_read = 1'b1;
      bus.d_addr = 32'h7F0;
      run_txn("starve_i", 1'b0, 1'b1, 1'b0, 1, 32'h6666);
      bus.i_read = 1'b1;
      bus.i_addr = 32'h610;
      run_txn("starve_clr", 1'b1, 1'b1, 1'b0, 0, 32'h7777);
      run_txn("starve_tail", 1'b0, 1'b1, 1'b0, 0, 32'h6161);

      // Abort: data read dropped one cycle into its grant, then a stray m_ready.
      bus.d_read = 1'b1;
      bus.d_addr = 32'h800;
      tick();
      chk("abort", "m_read", bus.m_read, 1'b1);
      tick();
      bus.d_read = 1'b0;
      tick();
      chk("abort", "release strobe", bus.m_read, 1'b0);
      chk("abort", "release busy", bus.busy, 1'b1);
      chk("abort", "no d_ready", bus.d_ready, 1'b0);
      bus.m_ready = 1'b1;
      bus.m_rdata = 32'hFFFF_FFFF;
      tick();
      chk("abort", "idle busy", bus.busy, 1'b0);
      chk("abort", "late d_ready", bus.d_ready, 1'b0);
      chk("abort", "d_rdata", bus.d_rdata, exp_d_rdata);
      tick();
      chk("abort", "ignored ready", {bus.i_ready, bus.d_ready, bus.busy}, 3'b000);
      chk("abort", "ignored strobe", {bus.m_read, bus.m_write}, 2'b00);
      bus.m_ready = 1'b0;
      starve_m = 0;

      // Reset while a fetch is granted.
      bus.i_read = 1'b1;
      bus.i_addr = 32'h900;
      tick();
      chk("rst", "granted", bus.m_read, 1'b1);
      #2 reset = 1'b0;
      #1;
      chk("rst", "strobes", {bus.m_read, bus.m_write}, 2'b00);
      chk("rst", "readies", {bus.i_ready, bus.d_ready}, 2'b00);
      chk("rst", "busy", bus.busy, 1'b0);
      chk("rst", "rdata", {bus.i_rdata, bus.d_rdata}, '0);
      @(negedge clock);
      reset = 1'b1;
      exp_i_rdata = '0;
      exp_d_rdata = '0;
      starve_m = 0;
      run_txn("rst_regrant", 1'b0, 1'b1, 1'b0, 1, 32'h99990000);

      // Randomized traffic; the losing requester keeps its request across accesses.
      for (int n = 0; n < 60; n++) begin
         if (!bus.i_read && ($urandom_range(0, 1) == 1)) begin
            bus.i_read = 1'b1;
            bus.i_addr = $urandom;
         end
         if (!(bus.d_read || bus.d_write) && ($urandom_range(0, 3) != 0)) begin
            op = $urandom_range(0, 2);
            bus.d_read  = (op != 1);
            bus.d_write = (op != 0);
            bus.d_addr  = $urandom;
            bus.d_wdata = $urandom;
         end
         if (!bus.i_read && !bus.d_read && !bus.d_write) begin
            bus.i_read = 1'b1;
            bus.i_addr = $urandom;
         end
         ip = bus.i_read;
         dp = bus.d_read | bus.d_write;
         ed = dp && !(ip && (starve_m == LIM));
         run_txn($sformatf("rand%0d", n), ed,
                 ed ? (bus.d_read & ~bus.d_write) : 1'b1,
                 ed ? bus.d_write : 1'b0,
                 $urandom_range(0, 3), $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
